// File: rtl/mii_rx_ctrl_if.sv
// mii_rx_ctrl_if: byte stream input and frame/header/payload outputs of mii_rx_ctrl
interface mii_rx_ctrl_if;
  logic byte_rdy;
  logic [7:0] byte_d;
  logic frame_en;
  logic promisc;
  logic [47:0] hdr_dst;
  logic [47:0] hdr_src;
  logic [15:0] hdr_type;
  logic hdr_valid;
  logic pl_valid;
  logic [7:0] pl_data;
  logic [10:0] pl_len;
  logic frame_ok;
  logic frame_err;
  logic [1:0] err_code;
  logic busy;
  modport master (
    output byte_rdy, byte_d, frame_en, promisc,
    input hdr_dst, hdr_src, hdr_type, hdr_valid, pl_valid, pl_data, pl_len,
    input frame_ok, frame_err, err_code, busy
  );
  modport slave (
    input byte_rdy, byte_d, frame_en, promisc,
    output hdr_dst, hdr_src, hdr_type, hdr_valid, pl_valid, pl_data, pl_len,
    output frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/mii_rx_ctrl.sv
// mii_rx_ctrl: MII receive sequencer hunting preamble/SFD, filtering the header and forwarding payload
module mii_rx_ctrl #(
  parameter logic [47:0] MAC_ADDR = 48'h54_ff_01_21_23_24,
  parameter logic [7:0] PRE_BYTE = 8'hAA,
  parameter logic [7:0] SFD_BYTE = 8'hBA,
  parameter int unsigned PRE_MIN = 6,
  parameter int unsigned MAX_PAYLOAD = 1504
) (
  input logic clk,
  input logic reset,
  mii_rx_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;
  localparam logic [3:0] PMIN = 4'(PRE_MIN);
  localparam logic [10:0] PMAX = 11'(MAX_PAYLOAD);
  state_t state_q, state_d;
  logic byte_rdy_q, frame_en_q, stb, fall, drop;
  logic [1:0] code;
  logic [3:0] pcnt_q, pcnt_d, bcnt_q, bcnt_d;
  logic [47:0] dst_q, dst_d, src_q, src_d, addr;
  logic [15:0] type_q, type_d;
  logic [7:0] pl_data_q, pl_data_d;
  logic [10:0] pl_len_q, pl_len_d;
  logic [1:0] err_code_q, err_code_d;
  logic hdr_valid_q, hdr_valid_d, pl_valid_q, pl_valid_d;
  logic frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, busy_q, busy_d;
  assign stb = bus.byte_rdy & ~byte_rdy_q;
  assign fall = frame_en_q & ~bus.frame_en;
  assign addr = {dst_q[39:0], bus.byte_d};
  always_comb begin
    state_d = state_q;
    pcnt_d = pcnt_q;
    bcnt_d = bcnt_q;
    dst_d = dst_q;
    src_d = src_q;
    type_d = type_q;
    pl_data_d = pl_data_q;
    pl_len_d = pl_len_q;
    err_code_d = err_code_q;
    hdr_valid_d = 1'b0;
    pl_valid_d = 1'b0;
    frame_ok_d = 1'b0;
    frame_err_d = 1'b0;
    drop = 1'b0;
    code = 2'd0;
    if (stb) begin
      case (state_q)
        IDLE: if (bus.frame_en) begin
          state_d = bus.byte_d == PRE_BYTE ? PREAMBLE : IDLE;
          pcnt_d = 4'd1;
          drop = bus.byte_d != PRE_BYTE;
        end
        PREAMBLE: if (bus.byte_d == PRE_BYTE) begin
          pcnt_d = &pcnt_q ? pcnt_q : pcnt_q + 4'd1;
        end else if (bus.byte_d == SFD_BYTE && pcnt_q >= PMIN) begin
          state_d = DST;
          bcnt_d = 4'd0;
          dst_d = '0;
          src_d = '0;
          type_d = '0;
        end else begin
          drop = 1'b1;
        end
        DST: begin
          dst_d = addr;
          bcnt_d = bcnt_q == 4'd5 ? 4'd0 : bcnt_q + 4'd1;
          if (bcnt_q == 4'd5) begin
            state_d = SRC;
            drop = !(bus.promisc || addr == MAC_ADDR || &addr);
            code = 2'd1;
          end
        end
        SRC: begin
          src_d = {src_q[39:0], bus.byte_d};
          bcnt_d = bcnt_q == 4'd5 ? 4'd0 : bcnt_q + 4'd1;
          state_d = bcnt_q == 4'd5 ? TYPE : SRC;
        end
        TYPE: begin
          type_d = {type_q[7:0], bus.byte_d};
          bcnt_d = bcnt_q == 4'd1 ? 4'd0 : bcnt_q + 4'd1;
          hdr_valid_d = bcnt_q == 4'd1;
          state_d = bcnt_q == 4'd1 ? PAYLOAD : TYPE;
          pl_len_d = bcnt_q == 4'd1 ? 11'd0 : pl_len_q;
        end
        PAYLOAD: if (pl_len_q < PMAX) begin
          pl_valid_d = 1'b1;
          pl_data_d = bus.byte_d;
          pl_len_d = pl_len_q + 11'd1;
        end else begin
          drop = 1'b1;
          code = 2'd3;
        end
        default: ;
      endcase
    end
    if (drop) begin
      state_d = DROP;
      frame_err_d = 1'b1;
      err_code_d = code;
    end
    if (fall) begin
      frame_ok_d = state_d == PAYLOAD;
      if (state_d inside {PREAMBLE, DST, SRC, TYPE}) begin
        frame_err_d = 1'b1;
        err_code_d = 2'd2;
      end
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      byte_rdy_q <= 1'b0;
      frame_en_q <= 1'b0;
      pcnt_q <= '0;
      bcnt_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      type_q <= '0;
      pl_data_q <= '0;
      pl_len_q <= '0;
      err_code_q <= '0;
      hdr_valid_q <= 1'b0;
      pl_valid_q <= 1'b0;
      frame_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_rdy_q <= bus.byte_rdy;
      frame_en_q <= bus.frame_en;
      pcnt_q <= pcnt_d;
      bcnt_q <= bcnt_d;
      dst_q <= dst_d;
      src_q <= src_d;
      type_q <= type_d;
      pl_data_q <= pl_data_d;
      pl_len_q <= pl_len_d;
      err_code_q <= err_code_d;
      hdr_valid_q <= hdr_valid_d;
      pl_valid_q <= pl_valid_d;
      frame_ok_q <= frame_ok_d;
      frame_err_q <= frame_err_d;
      busy_q <= busy_d;
    end
  end
  assign bus.hdr_dst = dst_q;
  assign bus.hdr_src = src_q;
  assign bus.hdr_type = type_q;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.pl_valid = pl_valid_q;
  assign bus.pl_data = pl_data_q;
  assign bus.pl_len = pl_len_q;
  assign bus.frame_ok = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code = err_code_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_mii_rx_ctrl.sv
// tb_mii_rx_ctrl: scoreboard bench for mii_rx_ctrl with directed frames
module tb_mii_rx_ctrl;
  localparam logic [47:0] MAC = 48'h54ff01212324;
  localparam logic [47:0] SRCA = 48'h123456789abc;
  localparam logic [15:0] TY = 16'h1234;
  typedef struct {int kind; logic [111:0] val;} ev_t;
  logic clk = 1'b0, reset = 1'b0, sel = 1'b0, rdy = 1'b0, en = 1'b0, prm = 1'b0;
  logic [7:0] d = 8'h00;
  int compared = 0, mismatched = 0, h = 1;
  ev_t sb[$];
  string s = "Twas' on the good ship Venus....";
  always #5 clk = ~clk;
  mii_rx_ctrl_if b0();
  mii_rx_ctrl_if b1();
  assign b0.byte_rdy = rdy & ~sel;
  assign b0.byte_d = d;
  assign b0.frame_en = en & ~sel;
  assign b0.promisc = prm;
  assign b1.byte_rdy = rdy & sel;
  assign b1.byte_d = d;
  assign b1.frame_en = en & sel;
  assign b1.promisc = prm;
  mii_rx_ctrl dut0 (.clk(clk), .reset(reset), .bus(b0));
  mii_rx_ctrl #(.MAX_PAYLOAD(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  logic [47:0] o_dst, o_src;
  logic [15:0] o_type;
  logic [7:0] o_pd;
  logic [10:0] o_len;
  logic [1:0] o_code;
  logic o_hv, o_pv, o_ok, o_err, o_busy;
  logic [137:0] o_all;
  assign o_dst = sel ? b1.hdr_dst : b0.hdr_dst;
  assign o_src = sel ? b1.hdr_src : b0.hdr_src;
  assign o_type = sel ? b1.hdr_type : b0.hdr_type;
  assign o_hv = sel ? b1.hdr_valid : b0.hdr_valid;
  assign o_pv = sel ? b1.pl_valid : b0.pl_valid;
  assign o_pd = sel ? b1.pl_data : b0.pl_data;
  assign o_len = sel ? b1.pl_len : b0.pl_len;
  assign o_ok = sel ? b1.frame_ok : b0.frame_ok;
  assign o_err = sel ? b1.frame_err : b0.frame_err;
  assign o_code = sel ? b1.err_code : b0.err_code;
  assign o_busy = sel ? b1.busy : b0.busy;
  assign o_all = {o_dst, o_src, o_type, o_hv, o_pv, o_pd, o_len, o_ok, o_err, o_code, o_busy};
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pop(input int kind, input logic [111:0] val);
    ev_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d val %0h expected nothing", kind, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== val) begin
        mismatched++;
        $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h", kind, val, e.kind, e.val);
      end
    end
  endtask
  always @(negedge clk) begin
    if (o_hv) pop(0, {o_dst, o_src, o_type});
    if (o_pv) pop(1, 112'({o_len, o_pd}));
    if (o_ok) pop(2, 112'(o_len));
    if (o_err) pop(3, 112'(o_code));
    if (o_ok | o_err) chk("ok_err_exclusive", 160'(o_ok & o_err), 160'(0));
  end
  task automatic put(input logic [7:0] v);
    d = v;
    rdy = 1'b1;
    repeat (h) @(posedge clk);
    #1 rdy = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic put_last(input logic [7:0] v);
    d = v;
    rdy = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1 rdy = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic end_frame();
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic start_frame();
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ty);
    repeat (7) put(8'hAA);
    put(8'hBA);
    for (int i = 5; i >= 0; i--) put(dst[i*8+:8]);
    for (int i = 5; i >= 0; i--) put(src[i*8+:8]);
    put(ty[15:8]);
    put(ty[7:0]);
  endtask
  task automatic good(input logic [47:0] dst, input int n, input int mx, input bit co);
    sb.push_back('{0, {dst, SRCA, TY}});
    for (int i = 0; i < n && i < mx; i++) sb.push_back('{1, 112'({11'(i + 1), s[i % 32]})});
    if (n > mx) sb.push_back('{3, 112'(2'd3)});
    else sb.push_back('{2, 112'(n)});
    start_frame();
    hdr(dst, SRCA, TY);
    for (int i = 0; i < n; i++) begin
      if (co && i == n - 1) put_last(s[i % 32]);
      else put(s[i % 32]);
    end
    end_frame();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 160'(o_all), 160'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    good(MAC, 32, 1504, 1'b0);
    chk("good_pl_len", 160'(o_len), 160'(32));
    chk("good_busy", 160'(o_busy), 160'(0));
    sb.push_back('{3, 112'(2'd1)});
    start_frame();
    hdr(48'h54ff01212325, SRCA, TY);
    put(8'h11);
    put(8'h22);
    end_frame();
    chk("filter_code", 160'(o_code), 160'(1));
    prm = 1'b1;
    good(48'h54ff01212325, 4, 1504, 1'b0);
    prm = 1'b0;
    chk("err_code_hold", 160'(o_code), 160'(1));
    good(48'hffffffffffff, 3, 1504, 1'b0);
    sb.push_back('{3, 112'(2'd0)});
    start_frame();
    put(8'hAA);
    put(8'hAA);
    put(8'hBA);
    hdr(MAC, SRCA, TY);
    end_frame();
    chk("badpre_code", 160'(o_code), 160'(0));
    sb.push_back('{3, 112'(2'd0)});
    start_frame();
    put(8'hAA);
    put(8'hAA);
    put(8'h55);
    hdr(MAC, SRCA, TY);
    end_frame();
    good(MAC, 5, 1504, 1'b0);
    sb.push_back('{3, 112'(2'd2)});
    start_frame();
    repeat (7) put(8'hAA);
    put(8'hBA);
    for (int i = 5; i >= 0; i--) put(MAC[i*8+:8]);
    for (int i = 5; i >= 2; i--) put(SRCA[i*8+:8]);
    chk("runt_busy_before", 160'(o_busy), 160'(1));
    en = 1'b0;
    @(posedge clk);
    #1 chk("runt_busy_after", 160'(o_busy), 160'(0));
    repeat (2) @(posedge clk);
    #1 chk("runt_code", 160'(o_code), 160'(2));
    h = 5;
    good(MAC, 8, 1504, 1'b0);
    h = 1;
    chk("hold_pl_len", 160'(o_len), 160'(8));
    good(MAC, 6, 1504, 1'b1);
    chk("coincide_pl_len", 160'(o_len), 160'(6));
    sb.push_back('{0, {MAC, SRCA, TY}});
    for (int i = 0; i < 5; i++) sb.push_back('{1, 112'({11'(i + 1), s[i]})});
    start_frame();
    hdr(MAC, SRCA, TY);
    for (int i = 0; i < 5; i++) put(s[i]);
    reset = 1'b0;
    #1 chk("midreset_outputs", 160'(o_all), 160'(0));
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    good(MAC, 7, 1504, 1'b0);
    chk("after_reset_pl_len", 160'(o_len), 160'(7));
    sel = 1'b1;
    @(posedge clk);
    #1;
    good(MAC, 20, 16, 1'b0);
    chk("toolong_pl_len", 160'(o_len), 160'(16));
    chk("toolong_code", 160'(o_code), 160'(3));
    repeat (4) @(posedge clk);
    #1 chk("scoreboard_drained", 160'(sb.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mii_rx_ctrl.md
# mii_rx_ctrl

Receive-frame sequencer placed directly after `MIIcore`. It consumes the byte stream `MIIcore` delivers (`rdy`/`d`), hunts preamble and SFD, and captures and filters the Ethernet header. It forwards payload bytes downstream with per-byte strobes and reports each frame's end status (good, or error with cause).

## Interface

Parameters:
- `MAC_ADDR`, 48'h54_ff_01_21_23_24: station address accepted by the destination filter.
- `PRE_BYTE`, 8'hAA: preamble byte value as delivered by `MIIcore`.
- `SFD_BYTE`, 8'hBA: start-of-frame byte value as delivered by `MIIcore`.
- `PRE_MIN`, 6: minimum preamble bytes required before SFD.
- `MAX_PAYLOAD`, 1504: maximum bytes after type field, FCS included.

Ports:
- `clk` in 1: single clock. All inputs are synchronous to it; upstream synchronizes `MIIcore` outputs.
- `reset` in 1: asynchronous, active-low.
- `byte_rdy` in 1: `MIIcore` `rdy`, level. Each rising edge marks one new byte.
- `byte_d` in 8: `MIIcore` `d`, valid while `byte_rdy` is high.
- `frame_en` in 1: synchronized `mii_en`. High for the duration of the frame.
- `promisc` in 1: disables the destination filter.
- `hdr_dst` out 48, `hdr_src` out 48, `hdr_type` out 16: captured header, first byte in MSBs.
- `hdr_valid` out 1: one-cycle pulse when all 14 header bytes have been captured.
- `pl_valid` out 1: one-cycle pulse per payload byte.
- `pl_data` out 8: payload byte, qualified by `pl_valid`.
- `pl_len` out 11: payload bytes forwarded in the current or last frame.
- `frame_ok` out 1: one-cycle pulse for a good frame end.
- `frame_err` out 1: one-cycle pulse for a frame drop.
- `err_code` out 2: 0 BADPRE, 1 NOMATCH, 2 RUNT, 3 TOOLONG. Holds until the next `frame_err`.
- `busy` out 1: high in any state other than IDLE.

## Operation

- `stb = byte_rdy & ~byte_rdy_q`. A level held high for N cycles counts as exactly one byte.
- `fall = frame_en_q & ~frame_en`.
- States: IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP.
- **IDLE:** `stb` is ignored while `frame_en` is low.
  - `stb` with `frame_en` and `byte_d==PRE_BYTE` → PREAMBLE, `pcnt=1`.
  - Any other byte with `frame_en` high → DROP, err 0.
- **PREAMBLE:**
  - `PRE_BYTE` → `pcnt++`, saturating at 15.
  - `SFD_BYTE` with `pcnt>=PRE_MIN` → DST, and `hdr_*` are cleared.
  - `SFD_BYTE` with `pcnt<PRE_MIN`, or any other byte → DROP, err 0.
- **DST / SRC / TYPE:** shift in 6, 6 and 2 bytes respectively. The shift is `field <= {field[W-9:0], byte_d}`. A 4-bit byte counter tracks position.
- **Destination filter:** evaluated on the 6th DST byte, using the new byte.
  - Pass if `promisc`, the address equals `MAC_ADDR`, or the address equals 48'hFFFF_FFFF_FFFF → SRC.
  - Otherwise → DROP, err 1.
- **End of TYPE:** the 2nd TYPE byte pulses `hdr_valid` and moves to PAYLOAD with `pl_len=0`.
- **PAYLOAD:**
  - On each `stb`, if `pl_len<MAX_PAYLOAD`: `pl_valid`, `pl_data=byte_d`, `pl_len++`.
  - Otherwise the byte is not forwarded → DROP, err 3.
- **`fall`:**
  - In PAYLOAD → `frame_ok`, then IDLE.
  - In PREAMBLE/DST/SRC/TYPE → `frame_err`, err 2, then IDLE.
  - In DROP → IDLE, with no further pulse.
- **DROP:** ignores all bytes and remains until `frame_en` is low.
- **Simultaneous `stb` and `fall`:** the byte is processed first, then the end of frame.
  - In PAYLOAD, `pl_valid` and `frame_ok` pulse in the same cycle, and `pl_len` includes the byte.
  - If the byte itself triggers DROP, only `frame_err` is pulsed.
- `frame_ok` and `frame_err` are never pulsed in the same cycle.

## Timing

- All outputs are registered. Latency is 1 clk from the cycle `stb` is true to `pl_valid`/`hdr_valid`/`frame_*`.
- Upstream contract: `byte_rdy` is low for at least 1 clk between bytes, and `byte_d` is stable in the cycle `stb` is true.
- Reset (async assert, sync release): state IDLE; all outputs 0, including `hdr_*`, `pl_len`, `err_code` and `busy`.
- Reset mid-frame abandons the frame with no pulse. After release, a new preamble is required.
- Throughput: one byte every 2 clks minimum, with no stalls. There is no backpressure; downstream must accept every `pl_valid`.

## Test plan

- **Good frame:** 7×AA, BA, dst 54ff01212324, src 123456789abc, type 1234, the 32-byte "Twas' on the good ship Venus...", then drop `frame_en`.
  - → one `hdr_valid` with those fields, 32 `pl_valid` in order, `frame_ok`, `pl_len=32`, no `frame_err`.
- **Filter:** dst 54ff01212325 with `promisc=0` → `frame_err` code 1 one clk after the 6th dst byte, no `hdr_valid`. Same frame with `promisc=1`, or dst FFFFFFFFFFFF → accepted.
- **Bad preamble:**
  - 2×AA then BA → err 0, no header.
  - AA,AA,55 → err 0.
  - In both cases later bytes are ignored, and the next frame after `frame_en` low is received normally.
- **Runt:** `frame_en` drops after 10 header bytes → `frame_err` code 2, `busy` low the next clk.
- **Too long:** `MAX_PAYLOAD=16`, 20 payload bytes → 16 `pl_valid`, `frame_err` code 3 on the 17th byte, no `frame_ok` at `fall`.
- **Strobe and reset:**
  - `byte_rdy` held high for 5 clks per byte → each byte counted once.
  - Last payload byte `stb` coincident with `fall` → `pl_valid` and `frame_ok` in the same cycle.
  - `reset` low mid-payload → all outputs 0 immediately; the following good frame passes.
